// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter (fifo_wr_arb) and its rr_pick encoder.
package fifo_arb_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ADDR_BUS = 4;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_BURST    = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotate-priority encoder: first valid requester at or above i_rrPtr, wrapping around.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_reqValid,
  input  logic [IW-1:0]   i_rrPtr,
  output logic [IW-1:0]   o_pick,
  output logic            o_anyValid
);

  // Scanning from the farthest offset down lets the nearest valid requester win last.
  always_comb begin
    logic [IW-1:0] w_idx;
    w_idx      = '0;
    o_pick     = '0;
    o_anyValid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(i_rrPtr) + k) % NREQ);
      if (i_reqValid[w_idx]) begin
        o_pick     = w_idx;
        o_anyValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-locked write arbiter in front of a sync FIFO write port.
// Define FIFO_ARB_LEVEL_EN to build the FIFO occupancy mirror on 'level'.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_BUS = DEF_ADDR_BUS,
  parameter int NREQ     = DEF_NREQ,
  parameter int BURST    = DEF_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic                      fifo_re,
  output logic                      fifo_we,
  output logic [WIDTH-1:0]          fifo_din,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [ADDR_BUS:0]         level
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = $clog2(BURST + 1);

  arb_state_e    r_state;
  logic [IW-1:0] r_rrPtr;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_grantId;
  logic [CW-1:0] r_burstCnt;

  logic [IW-1:0] w_pick;
  logic          w_anyValid;
  logic [IW-1:0] w_cur;
  logic [IW-1:0] w_relPtr;
  logic          w_xfer;

  rr_pick #(.NREQ(NREQ)) u_rrPick (
    .i_reqValid (req_valid),
    .i_rrPtr    (r_rrPtr),
    .o_pick     (w_pick),
    .o_anyValid (w_anyValid)
  );

  assign w_cur    = (r_state == LOCK) ? r_owner : w_pick;
  assign w_relPtr = (w_cur == IW'(NREQ - 1)) ? '0 : w_cur + 1'b1;

  // Reset gates ready directly so nothing leaks through while rst is high.
  always_comb begin
    req_ready = '0;
    if (!rst && !fifo_full && ((r_state == LOCK) || w_anyValid))
      req_ready[w_cur] = 1'b1;
  end

  assign w_xfer   = |(req_valid & req_ready);
  assign fifo_we  = w_xfer;
  assign fifo_din = w_xfer ? req_data[w_cur*WIDTH +: WIDTH] : '0;
  assign grant_id = r_grantId;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_owner    <= '0;
      r_grantId  <= '0;
      r_burstCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyValid) begin
            r_owner   <= w_pick;
            r_grantId <= w_pick;
            // A single-beat burst is already complete after the granting cycle.
            if (w_xfer && (BURST == 1)) begin
              r_rrPtr    <= w_relPtr;
              r_burstCnt <= '0;
            end else begin
              r_state    <= LOCK;
              r_burstCnt <= w_xfer ? CW'(1) : '0;
            end
          end
        end
        LOCK: begin
          if (!req_valid[r_owner]) begin
            r_state    <= IDLE;
            r_rrPtr    <= w_relPtr;
            r_burstCnt <= '0;
          end else if (w_xfer) begin
            if (r_burstCnt == CW'(BURST - 1)) begin
              r_state    <= IDLE;
              r_rrPtr    <= w_relPtr;
              r_burstCnt <= '0;
            end else begin
              r_burstCnt <= r_burstCnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_LEVEL_EN
  localparam logic [ADDR_BUS:0] LVL_MAX = (ADDR_BUS + 1)'(DEPTH);

  logic [ADDR_BUS:0] r_level;
  logic              w_rd;

  assign w_rd = fifo_re && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_level <= '0;
    else if (fifo_we && !w_rd && (r_level != LVL_MAX))
      r_level <= r_level + 1'b1;
    else if (!fifo_we && w_rd && (r_level != '0))
      r_level <= r_level - 1'b1;
  end

  assign level = r_level;
`else
  logic w_unused;
  assign w_unused = &{1'b0, fifo_re, fifo_empty, DEPTH[0]};
  assign level    = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_wr_arb;
  import fifo_arb_pkg::*;

  localparam int WIDTH    = DEF_WIDTH;
  localparam int DEPTH    = DEF_DEPTH;
  localparam int ADDR_BUS = DEF_ADDR_BUS;
  localparam int NREQ     = DEF_NREQ;
  localparam int BURST    = DEF_BURST;
  localparam int GW       = $clog2(NREQ);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_re;
  logic                    fifo_we;
  logic [WIDTH-1:0]        fifo_din;
  logic [GW-1:0]           grant_id;
  logic [ADDR_BUS:0]       level;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BUS(ADDR_BUS), .NREQ(NREQ), .BURST(BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .level      (level)
  );

  int nChecks = 0;
  int nErrors = 0;
  int nWrites = 0;

  // Reference model: who holds the port, beats used, where the next search starts.
  bit mLocked;
  int mOwner, mCnt, mPtr, mGrant;
  logic [WIDTH-1:0] fifoQ[$];

  logic [NREQ-1:0]  vld;
  logic [WIDTH-1:0] dat[NREQ];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int expLevel();
`ifdef FIFO_ARB_LEVEL_EN
    return fifoQ.size();
`else
    return 0;
`endif
  endfunction

  task automatic applyStimulus();
    req_valid = vld;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
    fifo_full  = (fifoQ.size() >= DEPTH);
    fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic modelRelease();
    mLocked = 1'b0;
    mPtr    = (mOwner + 1) % NREQ;
    mCnt    = 0;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then the registered ones after the edge.
  task automatic stepCycle(output bit xfer, output int who);
    int  cand;
    bit  anyv;
    bit  full;
    logic [NREQ-1:0]  expEff;
    logic [WIDTH-1:0] expDin;
    applyStimulus();
    #3;
    full = (fifoQ.size() >= DEPTH);
    anyv = 1'b0;
    cand = 0;
    if (!mLocked) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mPtr + k) % NREQ;
        if (vld[i] && !anyv) begin
          anyv = 1'b1;
          cand = i;
        end
      end
    end
    who  = mLocked ? mOwner : cand;
    xfer = !full && (mLocked || anyv) && vld[who];
    expEff = '0;
    if (xfer) expEff[who] = 1'b1;
    expDin = xfer ? dat[who] : '0;
    checkOutput("ready_and_valid", 32'(req_ready & req_valid), 32'(expEff));
    checkOutput("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
    if (mLocked) checkOutput("ready_owner", 32'(req_ready[mOwner]), 32'(!full));
    checkOutput("fifo_we", 32'(fifo_we), 32'(xfer));
    checkOutput("fifo_din", 32'(fifo_din), 32'(expDin));
    if (fifo_we === 1'b1) nWrites++;
    @(posedge clk);
    if (fifo_re && fifoQ.size() > 0) void'(fifoQ.pop_front());
    if (xfer) fifoQ.push_back(dat[who]);
    if (!mLocked) begin
      if (anyv) begin
        mLocked = 1'b1;
        mOwner  = cand;
        mGrant  = cand;
        mCnt    = xfer ? 1 : 0;
        if (mCnt == BURST) modelRelease();
      end
    end else if (!vld[mOwner]) begin
      modelRelease();
    end else if (xfer) begin
      mCnt++;
      if (mCnt == BURST) modelRelease();
    end
    #1;
    checkOutput("grant_id", 32'(grant_id), 32'(mGrant));
    checkOutput("level", 32'(level), 32'(expLevel()));
  endtask

  // Asserts rst immediately (mid-cycle), checks there is no leakage, then releases it.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_we", 32'(fifo_we), 32'd0);
    mLocked = 1'b0; mOwner = 0; mCnt = 0; mPtr = 0; mGrant = 0;
    fifoQ.delete();
    vld     = '0;
    fifo_re = 1'b0;
    applyStimulus();
    @(posedge clk);
    #1;
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic randomDrive(input bit xfer, input int who);
    if (xfer) begin
      if ($urandom_range(0, 3) == 0) vld[who] = 1'b0;
      else dat[who] = WIDTH'($urandom);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!vld[i] && ($urandom_range(0, 1) == 1)) begin
        vld[i] = 1'b1;
        dat[i] = WIDTH'($urandom);
      end
    end
    fifo_re = ($urandom_range(0, 9) < 4);
  endtask

  initial begin
    bit xfer;
    int who;
    int cnt;
    int base;
    vld = '0;
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    fifo_re = 1'b0;
    applyStimulus();
    doReset();

    // Requester 0 alone streams 0x10..0x15.
    base = nWrites;
    cnt  = 0;
    vld[0] = 1'b1;
    dat[0] = 8'h10;
    for (int c = 0; c < 20 && cnt < 6; c++) begin
      stepCycle(xfer, who);
      if (xfer) begin
        cnt++;
        dat[0] = WIDTH'(8'h10 + cnt);
        if (cnt == 6) vld[0] = 1'b0;
      end
    end
    stepCycle(xfer, who);
    checkOutput("A_writes", 32'(nWrites - base), 32'd6);
`ifdef FIFO_ARB_LEVEL_EN
    checkOutput("A_level", 32'(level), 32'd6);
`else
    checkOutput("A_level", 32'(level), 32'd0);
`endif

    // All requesters continuously valid while the consumer drains: no bubbles.
    base    = nWrites;
    fifo_re = 1'b1;
    vld     = '1;
    for (int i = 0; i < NREQ; i++) dat[i] = WIDTH'($urandom);
    for (int c = 0; c < 24; c++) begin
      stepCycle(xfer, who);
      if (xfer) dat[who] = WIDTH'($urandom);
    end
    checkOutput("B_nobubble", 32'(nWrites - base), 32'd24);
    vld = '0;
    for (int c = 0; c < 40 && fifoQ.size() > 0; c++) stepCycle(xfer, who);

    // Fill the FIFO from requester 2, then free one slot.
    fifo_re = 1'b0;
    base    = nWrites;
    vld[2]  = 1'b1;
    dat[2]  = 8'hA0;
    for (int c = 0; c < 20; c++) begin
      stepCycle(xfer, who);
      if (xfer) dat[2] = dat[2] + 1'b1;
    end
    checkOutput("C_accepted", 32'(nWrites - base), 32'd16);
    checkOutput("C_stall_ready", 32'(req_ready[2]), 32'd0);
    checkOutput("C_stall_grant", 32'(grant_id), 32'd2);
    fifo_re = 1'b1;
    stepCycle(xfer, who);
    fifo_re = 1'b0;
    stepCycle(xfer, who);
    checkOutput("C_after_read", 32'(nWrites - base), 32'd17);
`ifdef FIFO_ARB_LEVEL_EN
    checkOutput("C_level", 32'(level), 32'd16);
`else
    checkOutput("C_level", 32'(level), 32'd0);
`endif

    // Owner 1 drops valid after two writes; requester 3 outranks 0.
    doReset();
    vld[1] = 1'b1; dat[1] = 8'h31;
    vld[3] = 1'b1; dat[3] = 8'h73;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 2; c++) begin
      stepCycle(xfer, who);
      if (xfer) begin
        cnt++;
        dat[who] = dat[who] + 1'b1;
      end
    end
    checkOutput("D_owner1", 32'(grant_id), 32'd1);
    vld[1] = 1'b0;
    vld[0] = 1'b1; dat[0] = 8'h05;
    base = nWrites;
    stepCycle(xfer, who);
    checkOutput("D_bubble", 32'(nWrites - base), 32'd0);
    stepCycle(xfer, who);
    checkOutput("D_grant3", 32'(grant_id), 32'd3);

    // Reset in the middle of a burst owned by requester 2.
    doReset();
    vld[2] = 1'b1; dat[2] = 8'hC0;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 2; c++) begin
      stepCycle(xfer, who);
      if (xfer) begin
        cnt++;
        dat[2] = dat[2] + 1'b1;
      end
    end
    #1;
    doReset();
    vld[0] = 1'b1; dat[0] = 8'h40;
    vld[2] = 1'b1; dat[2] = 8'hC8;
    stepCycle(xfer, who);
    checkOutput("E_first_grant", 32'(grant_id), 32'd0);
    if (xfer) dat[who] = dat[who] + 1'b1;

    // Build up to five entries, then write and read together.
    for (int c = 0; c < 20 && fifoQ.size() < 5; c++) begin
      stepCycle(xfer, who);
      if (xfer) dat[who] = dat[who] + 1'b1;
    end
    fifo_re = 1'b1;
    base = nWrites;
    stepCycle(xfer, who);
    checkOutput("F_write", 32'(nWrites - base), 32'd1);
`ifdef FIFO_ARB_LEVEL_EN
    checkOutput("F_level", 32'(level), 32'd5);
`else
    checkOutput("F_level", 32'(level), 32'd0);
`endif
    fifo_re = 1'b0;

    // Random traffic with a randomly stalling consumer.
    for (int c = 0; c < 600; c++) begin
      stepCycle(xfer, who);
      randomDrive(xfer, who);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
